mem_issue_queue: RTL and testbench
==================================

Name: mem_issue_queue

Overview:
- In-order issue queue for loads and stores, sitting directly upstream of the memory functional unit.
- Accepts renamed LW/SW micro-ops from dispatch and tracks source-operand readiness via two result-broadcast ports.
- Issues the oldest entry to the memory unit as a one-cycle pulse once its operands are ready and the unit reports ready.
- Strict program order keeps memory ordering trivially correct.

Parameters:
- SIZE, 32, data/immediate width
- REG_NUM, 64, physical registers; tag width TW=$clog2(REG_NUM)
- ALUOP_BITS, 3, opcode width; LW=3'b101, SW=3'b110
- ROB_ROWS, 16, ROB entries; RW=$clog2(ROB_ROWS)
- DEPTH, 4, queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- disp_valid  in  1  dispatch offers a micro-op
- disp_ready  out  1  queue can accept (count<DEPTH)
- disp_aluop  in  ALUOP_BITS  opcode
- disp_src1, disp_src2  in  TW each  base reg / store-data reg
- disp_src1_rdy, disp_src2_rdy  in  1 each  operand already available at dispatch
- disp_dest  in  TW  load destination
- disp_imm  in  SIZE  offset
- disp_use_imm  in  1  passed through
- disp_robn  in  RW  ROB index
- bc_valid  in  2  broadcast valid, one per port
- bc_tag  in  2xTW  broadcast physical tags
- fu_ready  in  1  memory unit idle
- issue  out  1  one-cycle issue pulse
- iss_aluop, iss_src1, iss_src2, iss_dest, iss_imm, iss_use_imm, iss_robn  out  matching widths  registered fields of the issued entry
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async): head=tail=count=0, all entry valid bits 0, issue=0, all iss_* outputs 0. disp_ready=1 after reset release.
- Storage:
  - Circular buffer, head/tail pointers wrap modulo DEPTH.
  - Per entry: fields above plus rdy1, rdy2.
- Dispatch:
  - Handshake occurs on the edge where disp_valid && disp_ready; the entry is written at tail, then tail++.
  - disp_ready = (count<DEPTH), combinational from registered count only.
  - A micro-op presented while full is neither captured nor dropped; dispatch holds it.
- Wakeup:
  - Every edge, each valid entry sets rdy1 (rdy2) if any bc_valid[i] && bc_tag[i]==src1 (src2).
  - Same-cycle bypass: a dispatching entry whose source matches a broadcast that edge is written with rdy=1.
- Need rules:
  - LW needs rdy1 only.
  - SW needs rdy1 && rdy2.
  - Any other opcode needs nothing; it issues as a no-op so the memory unit can raise completion.
- Issue condition (evaluated on pre-edge state): head valid && needed-ready && fu_ready && !issue.
  - When true, on that edge: issue<=1, iss_* <= head fields, head invalidated, head++.
  - Otherwise issue<=0; iss_* hold their last values.
  - Consequence: minimum two cycles between issue pulses, which covers the unit's one-cycle-late ready drop on LW.
  - Only the head may issue. A ready younger entry waits behind a blocked head.
- Count arithmetic:
  - count += dispatch_fire − issue_fire.
  - Simultaneous dispatch and issue leaves count unchanged.
  - When full with an issue on the edge, disp_ready rises the next cycle, not the same cycle.
- Empty: no issue, iss_* stable.
- Reset mid-operation: all entries discarded immediately and any issue pulse is cut. No partial state survives.
- Broadcast of a tag not present, or to invalid entries: no effect.

Test Plan:
- Reset, then dispatch LW src1=5 rdy1=1, imm=8, dest=12, robn=3, fu_ready=1 -> issue high exactly one cycle, next cycle after capture; iss_src1=5, iss_imm=8, iss_dest=12, iss_robn=3; count returns 0.
- Dispatch SW src1=2 rdy, src2=9 not ready; broadcast tag 9 on port 1 three cycles later -> no issue before the broadcast; issue on the edge after wakeup with iss_aluop=3'b110.
- Fill 4 entries (none ready) -> disp_ready=0, count=4; a fifth disp_valid is held. Broadcast all tags -> entries issue in dispatch order (robn 0,1,2,3) with at least one idle cycle between pulses; disp_ready returns after the first issue.
- Dispatch an LW whose src1 equals bc_tag[0] in the same cycle (rdy1=0 at input) -> entry treated as ready and issues without a further broadcast.
- Head SW blocked on src2, younger LW ready -> LW does not issue until the SW issues; hold fu_ready=0 -> nothing issues while low.
- Assert rst asynchronously mid-cycle with 3 entries queued and issue high -> issue and count drop to 0 immediately; after release, pointers wrap correctly across 6 further dispatch/issue pairs.

Source files
------------

// File: rtl/mem_issue_queue.sv
// mem_issue_queue
// In-order issue queue for LW/SW micro-ops feeding the memory functional unit.
// Entries are held in a circular buffer. Source-operand readiness is tracked
// through two result-broadcast ports. Only the oldest entry may issue, and it
// issues as a one-cycle pulse with its fields held on the iss_* registers.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   disp_valid / disp_ready          dispatch handshake (ready while not full)
//   disp_aluop, disp_src1, disp_src2 opcode and source physical tags
//   disp_src1_rdy, disp_src2_rdy     operand already available at dispatch
//   disp_dest, disp_imm, disp_use_imm, disp_robn   payload carried to issue
//   bc_valid, bc_tag                 two result-broadcast ports (wakeup)
//   fu_ready                         memory unit idle
//   issue, iss_*                     registered issue pulse and issued fields
//   count                            occupied entries
module mem_issue_queue #(
    parameter int SIZE       = 32,
    parameter int REG_NUM    = 64,
    parameter int ALUOP_BITS = 3,
    parameter int ROB_ROWS   = 16,
    parameter int DEPTH      = 4,
    localparam int TW = $clog2(REG_NUM),
    localparam int RW = $clog2(ROB_ROWS),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [ALUOP_BITS-1:0] disp_aluop,
    input  logic [TW-1:0]         disp_src1,
    input  logic [TW-1:0]         disp_src2,
    input  logic                  disp_src1_rdy,
    input  logic                  disp_src2_rdy,
    input  logic [TW-1:0]         disp_dest,
    input  logic [SIZE-1:0]       disp_imm,
    input  logic                  disp_use_imm,
    input  logic [RW-1:0]         disp_robn,
    input  logic [1:0]            bc_valid,
    input  logic [1:0][TW-1:0]    bc_tag,
    input  logic                  fu_ready,
    output logic                  issue,
    output logic [ALUOP_BITS-1:0] iss_aluop,
    output logic [TW-1:0]         iss_src1,
    output logic [TW-1:0]         iss_src2,
    output logic [TW-1:0]         iss_dest,
    output logic [SIZE-1:0]       iss_imm,
    output logic                  iss_use_imm,
    output logic [RW-1:0]         iss_robn,
    output logic [CW-1:0]         count
);

    localparam logic [ALUOP_BITS-1:0] OP_LW   = ALUOP_BITS'(3'b101);
    localparam logic [ALUOP_BITS-1:0] OP_SW   = ALUOP_BITS'(3'b110);
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      rdy1_q, rdy1_d;
    logic [DEPTH-1:0]      rdy2_q, rdy2_d;
    logic [DEPTH-1:0]      use_imm_q, use_imm_d;
    logic [ALUOP_BITS-1:0] aluop_q [DEPTH];
    logic [ALUOP_BITS-1:0] aluop_d [DEPTH];
    logic [TW-1:0]         src1_q [DEPTH];
    logic [TW-1:0]         src1_d [DEPTH];
    logic [TW-1:0]         src2_q [DEPTH];
    logic [TW-1:0]         src2_d [DEPTH];
    logic [TW-1:0]         dest_q [DEPTH];
    logic [TW-1:0]         dest_d [DEPTH];
    logic [SIZE-1:0]       imm_q [DEPTH];
    logic [SIZE-1:0]       imm_d [DEPTH];
    logic [RW-1:0]         robn_q [DEPTH];
    logic [RW-1:0]         robn_d [DEPTH];

    // Pointers, occupancy and issue registers
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  issue_q, issue_d;
    logic [ALUOP_BITS-1:0] iss_aluop_q, iss_aluop_d;
    logic [TW-1:0]         iss_src1_q, iss_src1_d;
    logic [TW-1:0]         iss_src2_q, iss_src2_d;
    logic [TW-1:0]         iss_dest_q, iss_dest_d;
    logic [SIZE-1:0]       iss_imm_q, iss_imm_d;
    logic                  iss_use_imm_q, iss_use_imm_d;
    logic [RW-1:0]         iss_robn_q, iss_robn_d;

    logic disp_fire_s, issue_fire_s, head_need_ok_s;

    // True when either broadcast port carries the given tag this cycle
    function automatic logic tag_hit(input logic [TW-1:0] tag,
                                     input logic [1:0] vld,
                                     input logic [1:0][TW-1:0] tags);
        return (vld[0] && (tags[0] == tag)) || (vld[1] && (tags[1] == tag));
    endfunction

    assign disp_ready  = (count_q < DEPTH_C);
    assign disp_fire_s = disp_valid && disp_ready;

    // Operand requirement of the head entry, judged on registered readiness only
    always_comb begin
        head_need_ok_s = 1'b1;
        case (aluop_q[head_q])
            OP_LW:   head_need_ok_s = rdy1_q[head_q];
            OP_SW:   head_need_ok_s = rdy1_q[head_q] && rdy2_q[head_q];
            default: head_need_ok_s = 1'b1;
        endcase
    end

    // The !issue_q term enforces an idle cycle between pulses, covering the
    // memory unit's late ready drop after accepting a load.
    assign issue_fire_s = valid_q[head_q] && head_need_ok_s && fu_ready && !issue_q;

    // Next-state: wakeup, head issue, tail write and occupancy update
    always_comb begin
        valid_d = valid_q;   rdy1_d = rdy1_q;   rdy2_d = rdy2_q;
        use_imm_d = use_imm_q;
        aluop_d = aluop_q;   src1_d = src1_q;   src2_d = src2_q;
        dest_d  = dest_q;    imm_d  = imm_q;    robn_d = robn_q;
        head_d  = head_q;    tail_d = tail_q;   count_d = count_q;
        issue_d = 1'b0;
        iss_aluop_d = iss_aluop_q;  iss_src1_d = iss_src1_q;
        iss_src2_d  = iss_src2_q;   iss_dest_d = iss_dest_q;
        iss_imm_d   = iss_imm_q;    iss_use_imm_d = iss_use_imm_q;
        iss_robn_d  = iss_robn_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                rdy1_d[i] = rdy1_q[i] | tag_hit(src1_q[i], bc_valid, bc_tag);
                rdy2_d[i] = rdy2_q[i] | tag_hit(src2_q[i], bc_valid, bc_tag);
            end else begin
                rdy1_d[i] = rdy1_q[i];
                rdy2_d[i] = rdy2_q[i];
            end
        end

        if (issue_fire_s) begin
            issue_d       = 1'b1;
            iss_aluop_d   = aluop_q[head_q];
            iss_src1_d    = src1_q[head_q];
            iss_src2_d    = src2_q[head_q];
            iss_dest_d    = dest_q[head_q];
            iss_imm_d     = imm_q[head_q];
            iss_use_imm_d = use_imm_q[head_q];
            iss_robn_d    = robn_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end else begin
            issue_d = 1'b0;
        end

        // When not full the tail slot is free, so it never collides with the head
        if (disp_fire_s) begin
            valid_d[tail_q]   = 1'b1;
            aluop_d[tail_q]   = disp_aluop;
            src1_d[tail_q]    = disp_src1;
            src2_d[tail_q]    = disp_src2;
            rdy1_d[tail_q]    = disp_src1_rdy | tag_hit(disp_src1, bc_valid, bc_tag);
            rdy2_d[tail_q]    = disp_src2_rdy | tag_hit(disp_src2, bc_valid, bc_tag);
            dest_d[tail_q]    = disp_dest;
            imm_d[tail_q]     = disp_imm;
            use_imm_d[tail_q] = disp_use_imm;
            robn_d[tail_q]    = disp_robn;
            tail_d            = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        case ({disp_fire_s, issue_fire_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every entry and cuts any issue pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;  rdy1_q <= '0;  rdy2_q <= '0;  use_imm_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aluop_q[i] <= '0;  src1_q[i] <= '0;  src2_q[i] <= '0;
                dest_q[i]  <= '0;  imm_q[i]  <= '0;  robn_q[i] <= '0;
            end
            head_q <= '0;  tail_q <= '0;  count_q <= '0;  issue_q <= 1'b0;
            iss_aluop_q <= '0;  iss_src1_q <= '0;  iss_src2_q <= '0;
            iss_dest_q  <= '0;  iss_imm_q  <= '0;  iss_use_imm_q <= 1'b0;
            iss_robn_q  <= '0;
        end else begin
            valid_q <= valid_d;  rdy1_q <= rdy1_d;  rdy2_q <= rdy2_d;
            use_imm_q <= use_imm_d;
            aluop_q <= aluop_d;  src1_q <= src1_d;  src2_q <= src2_d;
            dest_q  <= dest_d;   imm_q  <= imm_d;   robn_q <= robn_d;
            head_q  <= head_d;   tail_q <= tail_d;  count_q <= count_d;
            issue_q <= issue_d;
            iss_aluop_q <= iss_aluop_d;  iss_src1_q <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;   iss_dest_q <= iss_dest_d;
            iss_imm_q   <= iss_imm_d;    iss_use_imm_q <= iss_use_imm_d;
            iss_robn_q  <= iss_robn_d;
        end
    end

    assign issue       = issue_q;
    assign iss_aluop   = iss_aluop_q;
    assign iss_src1    = iss_src1_q;
    assign iss_src2    = iss_src2_q;
    assign iss_dest    = iss_dest_q;
    assign iss_imm     = iss_imm_q;
    assign iss_use_imm = iss_use_imm_q;
    assign iss_robn    = iss_robn_q;
    assign count       = count_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
module tb_mem_issue_queue;

    localparam int LW = 5;   // 3'b101
    localparam int SW = 6;   // 3'b110

    logic            clk = 1'b0;
    logic            rst;
    logic            disp_valid, disp_ready;
    logic [2:0]      disp_aluop;
    logic [5:0]      disp_src1, disp_src2, disp_dest;
    logic            disp_src1_rdy, disp_src2_rdy, disp_use_imm;
    logic [31:0]     disp_imm;
    logic [3:0]      disp_robn;
    logic [1:0]      bc_valid;
    logic [1:0][5:0] bc_tag;
    logic            fu_ready, issue;
    logic [2:0]      iss_aluop;
    logic [5:0]      iss_src1, iss_src2, iss_dest;
    logic [31:0]     iss_imm;
    logic            iss_use_imm;
    logic [3:0]      iss_robn;
    logic [2:0]      count;

    mem_issue_queue dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_aluop(disp_aluop), .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_dest(disp_dest), .disp_imm(disp_imm), .disp_use_imm(disp_use_imm),
        .disp_robn(disp_robn), .bc_valid(bc_valid), .bc_tag(bc_tag),
        .fu_ready(fu_ready), .issue(issue),
        .iss_aluop(iss_aluop), .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_dest(iss_dest), .iss_imm(iss_imm), .iss_use_imm(iss_use_imm),
        .iss_robn(iss_robn), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [2:0]  op;
        logic [5:0]  s1;
        logic        r1;
        logic [5:0]  s2;
        logic        r2;
        logic [5:0]  dest;
        logic [31:0] imm;
        logic [3:0]  robn;
        logic [1:0]  bv;
        logic [5:0]  bt0;
        logic [5:0]  bt1;
        logic        fu;
        logic        ei;   // expected issue after the edge
        logic [2:0]  ec;   // expected count after the edge
        logic        er;   // expected disp_ready after the edge
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    logic [57:0] exp_q[$];
    logic [57:0] last_exp = '0;
    logic        prev_iss = 1'b0;
    vec_t        tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int dv, op, s1, r1, s2, r2, dest, imm, robn,
                                bv, bt0, bt1, fu, ei, ec, er);
        vec_t v;
        v.dv = 1'(dv);   v.op = 3'(op);   v.s1 = 6'(s1);  v.r1 = 1'(r1);
        v.s2 = 6'(s2);   v.r2 = 1'(r2);   v.dest = 6'(dest); v.imm = 32'(imm);
        v.robn = 4'(robn); v.bv = 2'(bv); v.bt0 = 6'(bt0); v.bt1 = 6'(bt1);
        v.fu = 1'(fu);   v.ei = 1'(ei);   v.ec = 3'(ec);  v.er = 1'(er);
        return v;
    endfunction

    function automatic vec_t idl(input int fu, bv, bt0, bt1, ei, ec, er);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, bv, bt0, bt1, fu, ei, ec, er);
    endfunction

    // One cycle: drive at negedge, push the expected issue record on a modelled
    // handshake, then compare issue/count/disp_ready just after the edge.
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        disp_valid = v.dv;  disp_aluop = v.op;
        disp_src1 = v.s1;   disp_src1_rdy = v.r1;
        disp_src2 = v.s2;   disp_src2_rdy = v.r2;
        disp_dest = v.dest; disp_imm = v.imm; disp_robn = v.robn;
        disp_use_imm = v.robn[0];
        bc_valid = v.bv;    bc_tag[0] = v.bt0; bc_tag[1] = v.bt1;
        fu_ready = v.fu;
        if (v.dv && model_cnt < 4)
            exp_q.push_back({v.op, v.s1, v.s2, v.dest, v.imm, v.robn[0], v.robn});
        @(posedge clk);
        #1;
        check({nm, " issue"}, 64'(issue), 64'(v.ei));
        check({nm, " count"}, 64'(count), 64'(v.ec));
        check({nm, " disp_ready"}, 64'(disp_ready), 64'(v.er));
        model_cnt = int'(v.ec);
    endtask

    // Scoreboard side: every issue pulse must match the oldest dispatched op
    always @(negedge clk) begin
        if (!rst) begin
            if (issue) begin
                check("issue spacing", 64'(prev_iss), 64'(0));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected issue: got robn %0d expected none", iss_robn);
                end else begin
                    logic [57:0] e;
                    e = exp_q.pop_front();
                    check("issued fields",
                          64'({iss_aluop, iss_src1, iss_src2, iss_dest, iss_imm, iss_use_imm, iss_robn}),
                          64'(e));
                    last_exp = e;
                end
            end
            prev_iss = issue;
        end else begin
            prev_iss = 1'b0;
        end
    end

    initial begin
        rst = 1'b1;
        disp_valid = 1'b0; disp_aluop = '0; disp_src1 = '0; disp_src2 = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_dest = '0; disp_imm = '0;
        disp_use_imm = 1'b0; disp_robn = '0; bc_valid = '0; bc_tag = '0; fu_ready = 1'b0;

        // Table: basic LW, SW wakeup, same-cycle bypass, stray broadcasts, no-op,
        // fill / hold / in-order drain.
        //            dv op  s1 r1 s2 r2 dst imm robn bv  bt0 bt1 fu  ei ec er
        tbl.push_back(mk(1, LW, 5, 1, 0, 0, 12, 8, 3,  0, 0, 0,  1,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, SW, 2, 1, 9, 0, 0, 32'h20, 4, 0, 0, 0, 1,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 1, 1));
        tbl.push_back(idl(1, 2, 0, 9,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, LW, 20, 0, 0, 0, 21, 32'h30, 5, 1, 20, 0, 1,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, LW, 30, 0, 0, 0, 31, 32'h34, 6, 3, 31, 29, 1,  0, 1, 1));
        tbl.push_back(idl(1, 0, 30, 30, 0, 1, 1));
        tbl.push_back(idl(1, 1, 30, 0,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 2, 0, 3, 32'h38, 7, 0, 0, 0, 1,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, LW, 40, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(1, LW, 41, 0, 0, 0, 2, 32'h104, 1, 0, 0, 0, 1, 0, 2, 1));
        tbl.push_back(mk(1, LW, 42, 0, 0, 0, 3, 32'h108, 2, 0, 0, 0, 1, 0, 3, 1));
        tbl.push_back(mk(1, LW, 43, 0, 0, 0, 4, 32'h10c, 3, 0, 0, 0, 1, 0, 4, 0));
        tbl.push_back(mk(1, LW, 44, 1, 0, 0, 5, 32'h110, 8, 0, 0, 0, 1, 0, 4, 0));
        tbl.push_back(mk(1, LW, 44, 1, 0, 0, 5, 32'h110, 8, 3, 40, 41, 1, 0, 4, 0));
        tbl.push_back(mk(1, LW, 44, 1, 0, 0, 5, 32'h110, 8, 3, 42, 43, 1, 1, 3, 1));
        tbl.push_back(mk(1, LW, 44, 1, 0, 0, 5, 32'h110, 8, 0, 0, 0, 1, 0, 4, 0));
        tbl.push_back(idl(1, 0, 0, 0,  1, 3, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 3, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 2, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 2, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 1, 1));
        tbl.push_back(idl(1, 0, 0, 0,  1, 0, 1));
        tbl.push_back(idl(1, 0, 0, 0,  0, 0, 1));

        // Reset state
        #12;
        check("reset issue", 64'(issue), 64'(0));
        check("reset count", 64'(count), 64'(0));
        check("reset iss fields",
              64'({iss_aluop, iss_src1, iss_src2, iss_dest, iss_imm, iss_use_imm, iss_robn}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready after reset", 64'(disp_ready), 64'(1));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Blocked head SW keeps a ready younger LW waiting; fu_ready low stalls issue
        step(mk(1, SW, 50, 1, 51, 0, 0, 32'h40, 9, 0, 0, 0, 1,  0, 1, 1), "blk sw");
        step(mk(1, LW, 52, 1, 0, 0, 53, 32'h44, 10, 0, 0, 0, 1, 0, 2, 1), "blk lw");
        for (int i = 0; i < 3; i++) step(idl(1, 0, 0, 0, 0, 2, 1), "blk wait");
        step(idl(0, 1, 51, 0, 0, 2, 1), "blk wake fu0");
        for (int i = 0; i < 2; i++) step(idl(0, 0, 0, 0, 0, 2, 1), "blk fu0");
        step(idl(1, 0, 0, 0, 1, 1, 1), "blk sw issue");
        step(idl(1, 0, 0, 0, 0, 1, 1), "blk gap");
        step(idl(1, 0, 0, 0, 1, 0, 1), "blk lw issue");
        step(idl(1, 0, 0, 0, 0, 0, 1), "blk idle");

        // Reset mid-operation with three entries queued and an issue pulse high
        for (int i = 0; i < 4; i++)
            step(mk(1, LW, 1 + i, 1, 0, 0, 2, 32'h50 + i, 11 + i, 0, 0, 0, 0,
                    0, i + 1, (i < 3) ? 1 : 0), "mid fill");
        step(idl(1, 0, 0, 0, 1, 3, 1), "mid issue");
        #2;
        rst = 1'b1;
        #1;
        check("mid rst issue", 64'(issue), 64'(0));
        check("mid rst count", 64'(count), 64'(0));
        check("mid rst iss_robn", 64'(iss_robn), 64'(0));
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Pointer wrap across six dispatch/issue pairs
        for (int k = 0; k < 6; k++) begin
            step(mk(1, (k % 2 == 0) ? LW : SW, 10 + k, 1, 20 + k, 1, 30 + k,
                    32'h200 + 4 * k, k, 0, 0, 0, 1, 0, 1, 1), "wrap disp");
            step(idl(1, 0, 0, 0, 1, 0, 1), "wrap issue");
        end
        for (int i = 0; i < 3; i++) step(idl(1, 0, 0, 0, 0, 0, 1), "empty idle");
        check("empty iss hold",
              64'({iss_aluop, iss_src1, iss_src2, iss_dest, iss_imm, iss_use_imm, iss_robn}),
              64'({3'(SW), 6'd15, 6'd25, 6'd35, 32'h214, 1'b1, 4'd5}));
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
